// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb blast scheduler.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FUSE  = 2'd1,
    ST_BLAST = 2'd2,
    ST_COOL  = 2'd3
  } state_e;

  localparam logic [1:0] SHAPE_CROSS = 2'd0;
  localparam logic [1:0] SHAPE_VERT  = 2'd1;
  localparam logic [1:0] SHAPE_HORIZ = 2'd2;

  localparam int unsigned TILE_BITS          = 5;
  localparam int unsigned COORD_W            = 11;
  localparam int unsigned DEF_FUSE_FRAMES    = 120;
  localparam int unsigned DEF_BLAST_FRAMES   = 30;
  localparam int unsigned DEF_COOL_FRAMES    = 15;

  // Undefined shape code 3 falls back to the cross pattern.
  function automatic logic [1:0] sanitize_shape(input logic [1:0] shape);
    return (shape == 2'd3) ? SHAPE_CROSS : shape;
  endfunction

endpackage

// File: rtl/bomb_blast_scheduler_if.sv
// Placement request/grant bundle between the two players and the scheduler.
interface bomb_blast_scheduler_if;
  logic [1:0] req;        // bit0 = player 1
  logic [7:0] req_tileX;  // {p2[7:4], p1[3:0]}
  logic [5:0] req_tileY;  // {p2[5:3], p1[2:0]}
  logic [3:0] req_shape;  // {p2[3:2], p1[1:0]}
  logic [1:0] grant;      // one-clk one-hot accept pulse

  modport master (output req, req_tileX, req_tileY, req_shape, input grant);
  modport slave  (input req, req_tileX, req_tileY, req_shape, output grant);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; pointer moves only when a grant is accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetN,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt_c
);

  // prio_q = 0 favours requester 0, 1 favours requester 1
  logic prio_q;
  logic prio_d;

  // One-hot winner selection
  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = prio_q ? 2'b10 : 2'b01;
      default: gnt_c = 2'b00;
    endcase
  end

  // After a grant, the other requester gets priority
  always_comb begin
    prio_d = prio_q;
    if (accept && (req != 2'b00)) prio_d = gnt_c[0];
  end

  // Pointer register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

endmodule

// File: rtl/bomb_blast_scheduler.sv
// Bomb lifecycle sequencer: IDLE -> FUSE -> BLAST -> COOLDOWN, paced by startOfFrame.
// Optional macro BLAST_REMOTE_DET_EN adds remote_det[1:0] for early detonation by the owner.
module bomb_blast_scheduler
  import bomb_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES  = bomb_pkg::DEF_FUSE_FRAMES,
  parameter int unsigned BLAST_FRAMES = bomb_pkg::DEF_BLAST_FRAMES,
  parameter int unsigned COOL_FRAMES  = bomb_pkg::DEF_COOL_FRAMES,
  parameter int unsigned TILE_BITS    = bomb_pkg::TILE_BITS
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
`ifdef BLAST_REMOTE_DET_EN
  input  logic [1:0]          remote_det,
`endif
  bomb_blast_scheduler_if.slave bus,
  output logic                busy,
  output logic                bomb_visible,
  output logic                blast,
  output logic [2:0]          blast_num,
  output logic                owner,
  output logic [3:0]          bomb_tileX,
  output logic [2:0]          bomb_tileY,
  output logic [10:0]         topLeftX,
  output logic [10:0]         topLeftY
);

  // A zero-length phase still lasts one frame
  localparam int unsigned FUSE_LEN  = (FUSE_FRAMES  == 0) ? 1 : FUSE_FRAMES;
  localparam int unsigned BLAST_LEN = (BLAST_FRAMES == 0) ? 1 : BLAST_FRAMES;
  localparam int unsigned COOL_LEN  = (COOL_FRAMES  == 0) ? 1 : COOL_FRAMES;
  localparam int unsigned MAX_LEN   = (FUSE_LEN > BLAST_LEN)
                                      ? ((FUSE_LEN > COOL_LEN) ? FUSE_LEN : COOL_LEN)
                                      : ((BLAST_LEN > COOL_LEN) ? BLAST_LEN : COOL_LEN);
  localparam int unsigned CNT_W     = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               vis_q, vis_d;
  logic               blast_q, blast_d;
  logic [2:0]         num_q, num_d;
  logic               owner_q, owner_d;
  logic [3:0]         tx_q, tx_d;
  logic [2:0]         ty_q, ty_d;
  logic [10:0]        tlx_q, tlx_d;
  logic [10:0]        tly_q, tly_d;

  logic [1:0]         gnt_c;
  logic               accept_c;
  logic               sel_owner_c;
  logic [3:0]         sel_tx_c;
  logic [2:0]         sel_ty_c;
  logic [1:0]         sel_shape_c;
  logic               frame_done_c;

  assign accept_c = (state_q == ST_IDLE) && (bus.req != 2'b00);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetN (resetN),
    .req    (bus.req),
    .accept (accept_c),
    .gnt_c  (gnt_c)
  );

  // Pick the winning player's request fields
  always_comb begin
    sel_owner_c = gnt_c[1];
    sel_tx_c    = sel_owner_c ? bus.req_tileX[7:4] : bus.req_tileX[3:0];
    sel_ty_c    = sel_owner_c ? bus.req_tileY[5:3] : bus.req_tileY[2:0];
    sel_shape_c = sel_owner_c ? bus.req_shape[3:2] : bus.req_shape[1:0];
  end

  // Current phase expires on the frame pulse that takes the counter from 1 to 0
  assign frame_done_c = startOfFrame && (cnt_q == CNT_W'(1));

  // Next-state, counter and latched-bomb logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = 2'b00;
    num_d   = num_q;
    owner_d = owner_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    tlx_d   = tlx_q;
    tly_d   = tly_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          grant_d = gnt_c;
          owner_d = sel_owner_c;
          num_d   = {1'b0, sanitize_shape(sel_shape_c)};
          tx_d    = sel_tx_c;
          ty_d    = sel_ty_c;
          tlx_d   = 11'((11'(sel_tx_c) - 11'd2) << TILE_BITS);
          tly_d   = 11'((11'(sel_ty_c) - 11'd2) << TILE_BITS);
          state_d = ST_FUSE;
          cnt_d   = CNT_W'(FUSE_LEN);
        end
      end
      ST_FUSE: begin
`ifdef BLAST_REMOTE_DET_EN
        if (remote_det[owner_q]) begin
          state_d = ST_BLAST;
          cnt_d   = CNT_W'(BLAST_LEN);
        end else
`endif
        if (frame_done_c) begin
          state_d = ST_BLAST;
          cnt_d   = CNT_W'(BLAST_LEN);
        end else if (startOfFrame) begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_BLAST: begin
        if (frame_done_c) begin
          state_d = ST_COOL;
          cnt_d   = CNT_W'(COOL_LEN);
        end else if (startOfFrame) begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_COOL: begin
        if (frame_done_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (startOfFrame) begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    vis_d   = (state_d == ST_FUSE);
    blast_d = (state_d == ST_BLAST);
  end

  // State and output registers; reset clears blast immediately
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      vis_q   <= 1'b0;
      blast_q <= 1'b0;
      num_q   <= 3'd0;
      owner_q <= 1'b0;
      tx_q    <= 4'd0;
      ty_q    <= 3'd0;
      tlx_q   <= 11'd0;
      tly_q   <= 11'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      vis_q   <= vis_d;
      blast_q <= blast_d;
      num_q   <= num_d;
      owner_q <= owner_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tlx_q   <= tlx_d;
      tly_q   <= tly_d;
    end
  end

  assign bus.grant    = grant_q;
  assign busy         = busy_q;
  assign bomb_visible = vis_q;
  assign blast        = blast_q;
  assign blast_num    = num_q;
  assign owner        = owner_q;
  assign bomb_tileX   = tx_q;
  assign bomb_tileY   = ty_q;
  assign topLeftX     = tlx_q;
  assign topLeftY     = tly_q;

endmodule

// File: tb/tb_bomb_blast_scheduler.sv
// Self-checking bench for bomb_blast_scheduler: vector table plus lifecycle/reset/arbitration sequences.
module tb_bomb_blast_scheduler;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sof = 1'b0;
`ifdef BLAST_REMOTE_DET_EN
  logic [1:0]  remote_det = 2'b00;
`endif
  logic        busy, bomb_visible, blast, owner;
  logic [2:0]  blast_num;
  logic [3:0]  bomb_tileX;
  logic [2:0]  bomb_tileY;
  logic [10:0] topLeftX, topLeftY;

  bomb_blast_scheduler_if bus ();

  bomb_blast_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
`ifdef BLAST_REMOTE_DET_EN
    .remote_det   (remote_det),
`endif
    .bus          (bus),
    .busy         (busy),
    .bomb_visible (bomb_visible),
    .blast        (blast),
    .blast_num    (blast_num),
    .owner        (owner),
    .bomb_tileX   (bomb_tileX),
    .bomb_tileY   (bomb_tileY),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  grant;
    logic        owner;
    logic [2:0]  num;
    logic [3:0]  tx;
    logic [2:0]  ty;
    logic [10:0] tlx;
    logic [10:0] tly;
  } exp_t;

  typedef struct {
    int          player;
    logic [3:0]  tx;
    logic [2:0]  ty;
    logic [1:0]  shape;
    bit          sof_at_grant;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int n_checks = 0;
  int n_fail   = 0;
  int stray_grants = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One video frame: idle clocks then a frame pulse; returns just after the pulse edge
  task automatic frame();
    for (int i = 0; i < 3; i++) begin
      sof = (i == 2);
      tick();
      if (bus.grant != 2'b00) stray_grants++;
    end
    sof = 1'b0;
  endtask

  // Place one player's request fields; the other player's fields hold junk
  task automatic set_player(input int p, input logic [3:0] tx, input logic [2:0] ty,
                            input logic [1:0] sh);
    if (p == 0) begin
      bus.req_tileX[3:0] = tx;
      bus.req_tileY[2:0] = ty;
      bus.req_shape[1:0] = sh;
    end else begin
      bus.req_tileX[7:4] = tx;
      bus.req_tileY[5:3] = ty;
      bus.req_shape[3:2] = sh;
    end
  endtask

  task automatic randomize_fields();
    bus.req_tileX = 8'($urandom);
    bus.req_tileY = 6'($urandom);
    bus.req_shape = 4'($urandom);
  endtask

  // Called one edge after a request was presented in IDLE
  task automatic check_grant(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_grant"}, bus.grant, e.grant);
    check({tag, "_owner"}, owner, e.owner);
    check({tag, "_blast_num"}, blast_num, e.num);
    check({tag, "_tileX"}, bomb_tileX, e.tx);
    check({tag, "_tileY"}, bomb_tileY, e.ty);
    check({tag, "_topLeftX"}, topLeftX, e.tlx);
    check({tag, "_topLeftY"}, topLeftY, e.tly);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_visible"}, bomb_visible, 1'b1);
    check({tag, "_blast_low"}, blast, 1'b0);
    tick();
    check({tag, "_grant_width"}, bus.grant, 2'b00);
  endtask

  // Count frame pulses spent in each remaining phase
  task automatic run_life(output int f, output int b, output int c);
    f = 0; b = 0; c = 0;
    while (!blast && f < 1000) begin frame(); f++; end
    while (blast && b < 1000) begin frame(); b++; end
    while (busy && c < 1000) begin frame(); c++; end
  endtask

  task automatic check_life(input string tag, input int ef);
    int f, b, c;
    run_life(f, b, c);
    check({tag, "_fuse_frames"}, 32'(f), 32'(ef));
    check({tag, "_blast_frames"}, 32'(b), 32'd30);
    check({tag, "_cool_frames"}, 32'(c), 32'd15);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, b, c;

    vecs[0] = '{0, 4'd5,  3'd3, 2'd1, 1'b0, '{2'b01, 1'b0, 3'd1, 4'd5,  3'd3, 11'd96,   11'd32}};
    vecs[1] = '{1, 4'd0,  3'd1, 2'd3, 1'b1, '{2'b10, 1'b1, 3'd0, 4'd0,  3'd1, 11'h7C0,  11'h7E0}};
    vecs[2] = '{0, 4'd15, 3'd7, 2'd2, 1'b0, '{2'b01, 1'b0, 3'd2, 4'd15, 3'd7, 11'd416,  11'd160}};
    vecs[3] = '{1, 4'd2,  3'd2, 2'd0, 1'b1, '{2'b10, 1'b1, 3'd0, 4'd2,  3'd2, 11'd0,    11'd0}};
    vecs[4] = '{0, 4'd1,  3'd0, 2'd3, 1'b0, '{2'b01, 1'b0, 3'd0, 4'd1,  3'd0, 11'h7E0,  11'h7C0}};

    bus.req = 2'b00;
    randomize_fields();
    resetN = 1'b0;
    tick(); tick();
    check("reset_grant", bus.grant, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_visible", bomb_visible, 1'b0);
    check("reset_blast", blast, 1'b0);
    check("reset_outputs", {blast_num, owner, bomb_tileX, bomb_tileY, topLeftX, topLeftY}, 32'd0);
    resetN = 1'b1;
    tick();

    // Both players request, held across two lifecycles: P1 first, then P2
    set_player(0, 4'd3, 3'd4, 2'd0);
    set_player(1, 4'd6, 3'd2, 2'd2);
    bus.req = 2'b11;
    sb.push_back('{2'b01, 1'b0, 3'd0, 4'd3, 3'd4, 11'd32, 11'd64});
    tick();
    check_grant("rr_first");
    check_life("rr_first", 120);
    sb.push_back('{2'b10, 1'b1, 3'd2, 4'd6, 3'd2, 11'd128, 11'd0});
    tick();
    check_grant("rr_second");
    bus.req = 2'b00;
    check_life("rr_second", 120);

    // Vector table: single-player placements with full lifecycle
    for (int i = 0; i < 5; i++) begin
      randomize_fields();
      set_player(vecs[i].player, vecs[i].tx, vecs[i].ty, vecs[i].shape);
      bus.req = (vecs[i].player == 0) ? 2'b01 : 2'b10;
      sof = vecs[i].sof_at_grant;
      sb.push_back(vecs[i].exp);
      tick();
      sof = 1'b0;
      bus.req = 2'b00;
      check_grant($sformatf("vec%0d", i));
      stray_grants = 0;
      check_life($sformatf("vec%0d", i), 120);
      check($sformatf("vec%0d_stray_grant", i), 32'(stray_grants), 32'd0);
    end

    // P2 requests while P1's bomb is live: ignored until IDLE, then granted next cycle
    randomize_fields();
    set_player(0, 4'd7, 3'd2, 2'd1);
    set_player(1, 4'd9, 3'd5, 2'd1);
    bus.req = 2'b01;
    sb.push_back('{2'b01, 1'b0, 3'd1, 4'd7, 3'd2, 11'd160, 11'd0});
    tick();
    check_grant("busy_p1");
    bus.req = 2'b10;
    stray_grants = 0;
    run_life(f, b, c);
    check("busy_stray_grant", 32'(stray_grants), 32'd0);
    check("busy_owner_kept", owner, 1'b0);
    check("busy_fuse_frames", 32'(f), 32'd120);
    sb.push_back('{2'b10, 1'b1, 3'd1, 4'd9, 3'd5, 11'd224, 11'd96});
    tick();
    check_grant("busy_p2");
    bus.req = 2'b00;
    check_life("busy_p2", 120);

    // Reset pulse in the middle of BLAST
    randomize_fields();
    set_player(0, 4'd4, 3'd4, 2'd2);
    bus.req = 2'b01;
    sb.push_back('{2'b01, 1'b0, 3'd2, 4'd4, 3'd4, 11'd64, 11'd64});
    tick();
    check_grant("rst_p1");
    bus.req = 2'b00;
    f = 0;
    while (!blast && f < 1000) begin frame(); f++; end
    for (int i = 0; i < 5; i++) frame();
    check("rst_pre_blast", blast, 1'b1);
    resetN = 1'b0;
    #1;
    check("rst_async_blast", blast, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_topLeft", {topLeftX, topLeftY}, 32'd0);
    tick();
    resetN = 1'b1;
    tick();
    // Pointer was reset, so P1 wins again despite winning last
    set_player(0, 4'd2, 3'd3, 2'd0);
    set_player(1, 4'd8, 3'd1, 2'd1);
    bus.req = 2'b11;
    sb.push_back('{2'b01, 1'b0, 3'd0, 4'd2, 3'd3, 11'd0, 11'd32});
    tick();
    check_grant("rst_after");
    bus.req = 2'b00;
    check_life("rst_after", 120);

`ifdef BLAST_REMOTE_DET_EN
    // Owner's remote detonation cuts FUSE short; non-owner bit has no effect
    randomize_fields();
    set_player(0, 4'd5, 3'd5, 2'd1);
    bus.req = 2'b01;
    sb.push_back('{2'b01, 1'b0, 3'd1, 4'd5, 3'd5, 11'd96, 11'd96});
    tick();
    check_grant("rdet");
    bus.req = 2'b00;
    for (int i = 0; i < 10; i++) frame();
    remote_det = 2'b10;
    for (int i = 0; i < 3; i++) frame();
    check("rdet_nonowner_blast", blast, 1'b0);
    check("rdet_nonowner_visible", bomb_visible, 1'b1);
    remote_det = 2'b01;
    tick();
    remote_det = 2'b00;
    check("rdet_blast_rise", blast, 1'b1);
    check_life("rdet", 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
